// File: rtl/priority_interrupt_controller.sv
// priority_interrupt_controller
//
// Memory-mapped interrupt controller for the MIPS microcontroller. It collects
// NUM_IRQ request lines and gives each one an enable mask bit, an edge/level
// mode bit and a software-visible pending bit. Requests are arbitrated by fixed
// priority, where the lowest index wins. The controller raises the single CPU
// interrupt line and holds it until software writes the serviced ID to INT_ACK.
//
// Optional build macro:
//   IRQ_SYNC_EN - when defined, each irq line goes through a 2-flop synchronizer
//                 before the edge/level logic. This adds 2 cycles to every
//                 request latency.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-low reset
//   address      register select (IRQ_ID, MASK, INT_ACK, MODE, PENDING)
//   rw           1 = write, 0 = read
//   ce           chip enable, a bus access happens only when 1
//   data_in      write data (the low NUM_IRQ bits are used, except for INT_ACK)
//   data_out     combinational read data, 0 whenever no read is in progress
//   irq          request lines
//   intr         interrupt request to the CPU (registered)
//   dbg_state_o  current arbitration state (0 = IDLE, 1 = WAIT_ACK)
//
// Bus access semantics: there is no valid/ready handshake. Each access
// completes in one cycle. A write (ce=1, rw=1) is committed at the rising edge
// on which it is presented. A read (ce=1, rw=0) returns data combinationally
// in the same cycle. The slave never stalls.
module priority_interrupt_controller #(
  parameter int          NUM_IRQ      = 8,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [2:0]  IRQ_ID_ADDR  = 3'd0,
  parameter logic [2:0]  MASK_ADDR    = 3'd1,
  parameter logic [2:0]  INT_ACK_ADDR = 3'd2,
  parameter logic [2:0]  MODE_ADDR    = 3'd3,
  parameter logic [2:0]  PENDING_ADDR = 3'd4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            address,
  input  logic                  rw,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [NUM_IRQ-1:0]    irq,
  output logic                  intr,
  output logic                  dbg_state_o
);

  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t              state_q;
  logic                intr_q;
  logic [ID_W-1:0]     irq_id_q, irq_id_d;
  logic [NUM_IRQ-1:0]  mask_q, mask_d;
  logic [NUM_IRQ-1:0]  mode_q, mode_d;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  irq_prev_q;
  logic [NUM_IRQ-1:0]  irq_s;

  // ---------------------------------------------------------------------------
  // Request input conditioning
  // ---------------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq;
`endif

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic wr_en, rd_en;
  logic ack_match;
  logic [NUM_IRQ-1:0] w1c, ack_clr, edge_set, active;

  assign wr_en = ce & rw;
  assign rd_en = ce & ~rw;

  // An ACK counts only while an interrupt is being signalled, and only if it
  // names the latched ID exactly. The full data word is compared, so a value
  // with stray upper bits does not match.
  assign ack_match = wr_en && (address == INT_ACK_ADDR) && (state_q == WAIT_ACK)
                     && (data_in == DATA_WIDTH'(irq_id_q));

  assign w1c      = (wr_en && (address == PENDING_ADDR)) ? data_in[NUM_IRQ-1:0] : '0;
  assign edge_set = irq_s & ~irq_prev_q;
  assign active   = pending_q & mask_q;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_clr[i] = ack_match && (irq_id_q == ID_W'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Pending, mask and mode next state
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (mode_q[i]) begin
        // Edge mode: a new edge beats a clear that arrives in the same cycle.
        pending_d[i] = edge_set[i] | (pending_q[i] & ~(ack_clr[i] | w1c[i]));
      end else begin
        // Level mode: pending is simply the registered request line.
        pending_d[i] = irq_s[i];
      end
    end
  end

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (wr_en && (address == MASK_ADDR)) mask_d = data_in[NUM_IRQ-1:0];
    if (wr_en && (address == MODE_ADDR)) mode_d = data_in[NUM_IRQ-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mask_q     <= '0;
      mode_q     <= '0;
      pending_q  <= '0;
      irq_prev_q <= '0;
    end else begin
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      pending_q  <= pending_d;
      irq_prev_q <= irq_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Fixed-priority encoder: scanning from the top down lets the lowest set
  // index be the last assignment, so it wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    irq_id_d = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) irq_id_d = ID_W'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration state machine. intr and irq_id are registered here. While in
  // WAIT_ACK, changes to mask or mode do not disturb the latched interrupt.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      intr_q   <= 1'b0;
      irq_id_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|active) begin
            irq_id_q <= irq_id_d;
            intr_q   <= 1'b1;
            state_q  <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_match) begin
            intr_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          intr_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign intr        = intr_q;
  assign dbg_state_o = state_q;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rdata;

  always_comb begin
    rdata = '0;
    case (address)
      IRQ_ID_ADDR:  rdata[ID_W-1:0]    = irq_id_q;
      MASK_ADDR:    rdata[NUM_IRQ-1:0] = mask_q;
      MODE_ADDR:    rdata[NUM_IRQ-1:0] = mode_q;
      PENDING_ADDR: rdata[NUM_IRQ-1:0] = pending_q;
      default:      rdata = '0;
    endcase
  end

  assign data_out = rd_en ? rdata : '0;

endmodule
